// File: rtl/uart_key_decoder.sv
// uart_key_decoder
//   Receives 8N1 ASCII bytes on a UART line and holds the last key as a 7-bit
//   code for the movement stage. Terminal autorepeat keeps the key alive. After
//   HOLD_CYCLES idle cycles the key is released to 0. A 0x00 byte releases the
//   key at once.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (minimum 4)
//   HOLD_CYCLES   idle cycles after the last accepted byte before release (minimum 2)
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   rx         in   asynchronous UART line, idle high
//   keyCode    out  held ASCII key, 0 = no key
//   key_valid  out  one-cycle pulse when keyCode is loaded from a received byte
//   frame_err  out  one-cycle pulse on a bad stop bit
module uart_key_decoder #(
  parameter int CLKS_PER_BIT = 564,
  parameter int HOLD_CYCLES  = 39_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [6:0] keyCode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [6:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [HW-1:0] hold_q, hold_d;

  logic start_tick, bit_tick, byte_done, accept, key_held, timeout;

  assign start_tick = (clk_cnt_q == HALF_M1);
  assign bit_tick   = (clk_cnt_q == BIT_M1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
      hold_q      <= hold_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s_q) state_d = S_START;
      S_START: if (start_tick) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:  if (bit_tick && bit_cnt_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (bit_tick) state_d = rx_s_q ? S_IDLE : S_BREAK;
      S_BREAK: if (rx_s_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver outputs: bit timing, shift register, stop-bit verdict
  always_comb begin
    clk_cnt_d   = clk_cnt_q + CW'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
      end
      S_START: if (start_tick) clk_cnt_d = '0;
      S_DATA: if (bit_tick) begin
        clk_cnt_d = '0;
        shift_d   = {rx_s_q, shift_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      S_STOP: if (bit_tick) begin
        clk_cnt_d   = '0;
        byte_done   = rx_s_q;
        frame_err_d = ~rx_s_q;
      end
      default: clk_cnt_d = '0;
    endcase
  end

  // Key hold: acceptance takes priority over the timeout release. Bytes with
  // bit 7 set leave the key and its hold counter running untouched.
  assign accept   = byte_done && !shift_q[7];
  assign key_held = (key_code_q != 7'd0);
  assign timeout  = key_held && (hold_q == HOLD_MAX);

  always_comb begin
    key_code_d  = key_code_q;
    hold_d      = hold_q;
    key_valid_d = accept;
    if (accept) begin
      key_code_d = shift_q[6:0];
      hold_d     = '0;
    end else if (timeout) begin
      key_code_d = 7'd0;
      hold_d     = '0;
    end else if (key_held && hold_q != HOLD_MAX) begin
      hold_d = hold_q + HW'(1);
    end
  end

  assign keyCode   = key_code_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_key_decoder.sv
module tb_uart_key_decoder;

  localparam int C    = 16;
  localparam int HOLD = 1000;
  // Pin falls in cycle p; two synchroniser stages, half-bit start check,
  // nine full bits to the stop sample, then one register stage.
  localparam int LAT  = 2 + C / 2 + 9 * C + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [6:0] keyCode;
  logic       key_valid;
  logic       frame_err;

  uart_key_decoder #(.CLKS_PER_BIT(C), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .keyCode(keyCode), .key_valid(key_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: expected outcome of each frame, keyed by the cycle the
  // outputs are due. 1 = load key, 2 = framing error.
  int         ev_kind [int];
  logic [6:0] ev_key  [int];
  logic [8:0] cap     [int];   // observed {frame_err, key_valid, keyCode} per cycle

  logic [6:0] ek = 7'd0;
  logic       ev_v, ef;
  int         last_load = -100000;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle model comparison
  initial begin
    int kind;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      cap[cyc] = {frame_err, key_valid, keyCode};
      ev_v = 1'b0;
      ef   = 1'b0;
      if (!rst) begin
        ek = 7'd0;
      end else begin
        kind = ev_kind.exists(cyc) ? ev_kind[cyc] : 0;
        if (kind == 1) begin
          ek = ev_key[cyc];
          last_load = cyc;
          ev_v = 1'b1;
        end else if (ek != 7'd0 && cyc - last_load == HOLD) begin
          ek = 7'd0;
        end
        ef = (kind == 2);
      end
      n_cmp++;
      if ({frame_err, key_valid, keyCode} !== {ef, ev_v, ek}) begin
        n_fail++;
        $display("FAIL cycle %0d outputs: got key=%h valid=%b ferr=%b, expected key=%h valid=%b ferr=%b",
                 cyc, keyCode, key_valid, frame_err, ek, ev_v, ef);
      end
    end
  end

  // Drives one frame starting at the current negedge; registers its outcome.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    t0 = cyc;
    if (!stop) ev_kind[t0 + LAT] = 2;
    else if (b < 8'h80) begin
      ev_kind[t0 + LAT] = 1;
      ev_key[t0 + LAT]  = b[6:0];
    end
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (C) @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic [6:0] exp_key;
    logic       exp_v;
    logic       exp_f;
  } vec_t;

  vec_t vt [12];
  int   vt_t0 [12];

  function automatic vec_t mk(input logic [7:0] d, input logic s, input int g,
                              input logic [6:0] k, input logic v, input logic f);
    vec_t r;
    r.data = d; r.stop = s; r.gap = g; r.exp_key = k; r.exp_v = v; r.exp_f = f;
    return r;
  endfunction

  task automatic apply_vec(input int i);
    int t0;
    send_frame(vt[i].data, vt[i].stop, t0);
    if (!vt[i].stop) begin
      repeat (40) @(negedge clk);
      rx = 1'b1;
    end
    repeat (vt[i].gap) @(negedge clk);
    vt_t0[i] = t0;
    chk($sformatf("vec%0d key", i),        int'(cap[t0 + LAT][6:0]), int'(vt[i].exp_key));
    chk($sformatf("vec%0d key_valid", i),  int'(cap[t0 + LAT][7]),   int'(vt[i].exp_v));
    chk($sformatf("vec%0d frame_err", i),  int'(cap[t0 + LAT][8]),   int'(vt[i].exp_f));
    chk($sformatf("vec%0d pulse width", i), int'(cap[t0 + LAT + 1][8:7]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int la, t0, t1, g0, pulses, nz, gap;
    logic [7:0] b;
    logic s;

    vt[0]  = mk(8'h64, 1'b1, 240, 7'h64, 1'b1, 1'b0);
    vt[1]  = mk(8'h64, 1'b1, 240, 7'h64, 1'b1, 1'b0);
    vt[2]  = mk(8'h64, 1'b1, 240, 7'h64, 1'b1, 1'b0);
    vt[3]  = mk(8'h64, 1'b1, 240, 7'h64, 1'b1, 1'b0);
    vt[4]  = mk(8'h64, 1'b1, 240, 7'h64, 1'b1, 1'b0);
    vt[5]  = mk(8'h61, 1'b1,   0, 7'h61, 1'b1, 1'b0);
    vt[6]  = mk(8'h44, 1'b1, 100, 7'h44, 1'b1, 1'b0);
    vt[7]  = mk(8'h55, 1'b0, 100, 7'h44, 1'b0, 1'b1);
    vt[8]  = mk(8'h41, 1'b1, 100, 7'h41, 1'b1, 1'b0);
    vt[9]  = mk(8'hE4, 1'b1, 100, 7'h41, 1'b0, 1'b0);
    vt[10] = mk(8'h64, 1'b1, 100, 7'h64, 1'b1, 1'b0);
    vt[11] = mk(8'h00, 1'b1, 100, 7'h00, 1'b1, 1'b0);

    // Reset held with the line toggling
    @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      rx = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("reset key", int'(keyCode), 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    // First key and autorepeat every 400 cycles
    for (int i = 0; i <= 4; i++) apply_vec(i);

    // Timeout release after the last repeat
    la = vt_t0[4] + LAT;
    while (cyc < la + HOLD + 5) @(negedge clk);
    chk("timeout last held",  int'(cap[la + HOLD - 1][6:0]), 'h64);
    chk("timeout released",   int'(cap[la + HOLD][6:0]), 0);
    chk("timeout no pulse",   int'(cap[la + HOLD][7]), 0);

    // Key switch, framing error, re-sync, filtered byte
    for (int i = 5; i <= 9; i++) apply_vec(i);

    // Short glitch on the line
    g0 = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    pulses = 0;
    for (int t = g0; t <= cyc; t++) pulses |= int'(cap[t][8:7]);
    chk("glitch pulses", pulses, 0);
    chk("glitch key", int'(keyCode), 'h41);

    // Reset during bit 3 of a 0x64 frame
    b = 8'h64;
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = b[3];
    repeat (C / 2) @(negedge clk);
    rst = 1'b0;
    ev_kind.delete();
    ev_key.delete();
    repeat (10) @(negedge clk);
    chk("midframe reset key", int'(cap[cyc][6:0]), 0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    apply_vec(10);
    apply_vec(11);

    // Acceptance landing exactly on the timeout cycle
    send_frame(8'h61, 1'b1, t0);
    la = t0 + LAT;
    while (cyc < t0 + HOLD) @(negedge clk);
    send_frame(8'h64, 1'b1, t1);
    repeat (20) @(negedge clk);
    chk("collide before", int'(cap[la + HOLD - 1][6:0]), 'h61);
    chk("collide after",  int'(cap[la + HOLD][6:0]), 'h64);
    nz = 1;
    for (int t = la; t <= la + HOLD + 15; t++) if (cap[t][6:0] == 7'd0) nz = 0;
    chk("collide never zero", nz, 1);

    // Random traffic against the model
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) b = 8'h00;
      s = ($urandom_range(0, 7) != 0);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(900, 1200) : $urandom_range(0, 300);
      send_frame(b, s, t0);
      if (!s) begin
        repeat ($urandom_range(1, 40)) @(negedge clk);
        rx = 1'b1;
        if (gap < C) gap = C;
      end
      repeat (gap) @(negedge clk);
    end
    repeat (HOLD + 200) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
